// File: rtl/qr_dispatch_ctrl.sv
// Round-robin frame dispatcher into NUM_CORES QR cores with an in-order result collector.
// Load strobes are combinational; results emerge 2 cycles after an in-order done; no backpressure, late duplicates flag o_ovf.
module qr_dispatch_ctrl #(
  parameter int NUM_CORES       = 2,
  parameter int WORDS_PER_FRAME = 20,
  parameter int FRAMES_PER_GRP  = 10,
  parameter int DATA_W          = 48,
  parameter int YHAT_W          = 160,
  parameter int R_W             = 320,
  localparam int WIDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_trig,
  input  logic [DATA_W-1:0]           i_data,
  output logic [NUM_CORES-1:0]        o_core_trig,
  output logic [DATA_W-1:0]           o_core_data,
  output logic [WIDX_W-1:0]           o_word_idx,
  input  logic [NUM_CORES-1:0]        i_core_done,
  input  logic [NUM_CORES*YHAT_W-1:0] i_core_y_hat,
  input  logic [NUM_CORES*R_W-1:0]    i_core_r,
  output logic                        o_rd_vld,
  output logic                        o_last_data,
  output logic [YHAT_W-1:0]           o_y_hat,
  output logic [R_W-1:0]              o_r,
  output logic                        o_ovf
);

  localparam int PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int FCNT_W = (FRAMES_PER_GRP > 1) ? $clog2(FRAMES_PER_GRP) : 1;
  localparam logic [WIDX_W-1:0] WCNT_MAX = WIDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(NUM_CORES - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FRAMES_PER_GRP - 1);

  logic [WIDX_W-1:0]    wcnt;
  logic [PTR_W-1:0]     lptr;
  logic [PTR_W-1:0]     optr;
  logic [FCNT_W-1:0]    fcnt;
  logic [NUM_CORES-1:0] slot_vld;
  logic [YHAT_W-1:0]    slot_y [NUM_CORES];
  logic [R_W-1:0]       slot_r [NUM_CORES];
  logic                 emit;
  logic [NUM_CORES-1:0] emit_sel;
  logic [NUM_CORES-1:0] cap;
  logic [NUM_CORES-1:0] ovf_hit;

  assign o_core_data = i_data;
  assign o_word_idx  = wcnt;
  assign emit        = slot_vld[optr];

  // A slot being emitted this cycle may be refilled in the same cycle without overflow.
  always_comb begin
    o_core_trig = '0;
    emit_sel    = '0;
    cap         = '0;
    ovf_hit     = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      o_core_trig[k] = i_trig & (lptr == PTR_W'(k)) & i_rst_n;
      emit_sel[k]    = emit & (optr == PTR_W'(k));
      cap[k]         = i_core_done[k] & (~slot_vld[k] | emit_sel[k]);
      ovf_hit[k]     = i_core_done[k] & slot_vld[k] & ~emit_sel[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wcnt <= '0;
      lptr <= '0;
    end else if (i_trig) begin
      if (wcnt == WCNT_MAX) begin
        wcnt <= '0;
        lptr <= (lptr == PTR_MAX) ? '0 : lptr + 1'b1;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      slot_vld <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (cap[k])
          slot_vld[k] <= 1'b1;
        else if (emit_sel[k])
          slot_vld[k] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_CORES; k++) begin
      if (cap[k]) begin
        slot_y[k] <= i_core_y_hat[k*YHAT_W +: YHAT_W];
        slot_r[k] <= i_core_r[k*R_W +: R_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      optr        <= '0;
      fcnt        <= '0;
      o_rd_vld    <= 1'b0;
      o_last_data <= 1'b0;
      o_y_hat     <= '0;
      o_r         <= '0;
      o_ovf       <= 1'b0;
    end else begin
      o_rd_vld    <= emit;
      o_last_data <= emit && (fcnt == FCNT_MAX);
      if (emit) begin
        o_y_hat <= slot_y[optr];
        o_r     <= slot_r[optr];
        optr    <= (optr == PTR_MAX) ? '0 : optr + 1'b1;
        fcnt    <= (fcnt == FCNT_MAX) ? '0 : fcnt + 1'b1;
      end
      if (|ovf_hit)
        o_ovf <= 1'b1;
    end
  end

endmodule
